// File: rtl/display_mux_scheduler.sv
// Time-multiplexes the 7x5 LED array between the irrigation-status frame
// and the tank-level frame, with blank gaps and an empty-tank alarm mode.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   tick_1hz            one-cycle pulse per second (dwell time base)
//   irrigation_status   irrigation code (2'b00 = idle)
//   water_tank_level    tank code (2'b00 = empty)
//   force_level         pins the display to the level frame while high
//   display_sel         0 = irrigation frame, 1 = level frame
//   display_code        code of the selected source
//   blank               turn all LEDs off
//   frame_start         pulse on the first visible cycle of a new frame
module display_mux_scheduler #(
    parameter int DWELL_IRR  = 3,
    parameter int DWELL_LVL  = 2,
    parameter int BLANK_CLKS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic [1:0] irrigation_status,
    input  logic [1:0] water_tank_level,
    input  logic       force_level,
    output logic       display_sel,
    output logic [1:0] display_code,
    output logic       blank,
    output logic       frame_start
);

    localparam int DMAX = (DWELL_IRR > DWELL_LVL) ? DWELL_IRR : DWELL_LVL;
    localparam int DW   = $clog2(DMAX + 1);
    localparam int BW   = $clog2(BLANK_CLKS + 1);

    localparam logic [DW-1:0] IRR_LAST = DW'(DWELL_IRR - 1);
    localparam logic [DW-1:0] LVL_LAST = DW'(DWELL_LVL - 1);
    localparam logic [BW-1:0] GAP_LAST = BW'(BLANK_CLKS - 1);

    typedef enum logic [2:0] {
        SHOW_IRR,
        GAP_TO_LVL,
        SHOW_LVL,
        GAP_TO_IRR,
        ALARM
    } state_t;

    state_t        state, state_n;
    logic [DW-1:0] dwell_cnt, dwell_n;
    logic [BW-1:0] gap_cnt, gap_n;
    logic          run;
    logic          alarm, tick_en;
    logic          sel_n, blank_n, fs_n;
    logic [1:0]    code_n;

    assign alarm = (water_tank_level == 2'b00) && (irrigation_status != 2'b00);
    // The first cycle out of reset is a frame change, so its tick is not counted.
    assign tick_en = tick_1hz && run;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= SHOW_IRR;
            dwell_cnt    <= '0;
            gap_cnt      <= '0;
            run          <= 1'b0;
            display_sel  <= 1'b0;
            display_code <= 2'b00;
            blank        <= 1'b1;
            frame_start  <= 1'b0;
        end else begin
            state        <= state_n;
            dwell_cnt    <= dwell_n;
            gap_cnt      <= gap_n;
            run          <= 1'b1;
            display_sel  <= sel_n;
            display_code <= code_n;
            blank        <= blank_n;
            frame_start  <= fs_n;
        end
    end

    always_comb begin
        state_n = state;
        dwell_n = dwell_cnt;
        gap_n   = gap_cnt;
        if (alarm) begin
            state_n = ALARM;
            dwell_n = '0;
            gap_n   = '0;
        end else begin
            unique case (state)
                SHOW_IRR: begin
                    if (force_level) begin
                        state_n = GAP_TO_LVL;
                        dwell_n = '0;
                        gap_n   = '0;
                    end else if (tick_en) begin
                        if (dwell_cnt == IRR_LAST) begin
                            state_n = GAP_TO_LVL;
                            dwell_n = '0;
                            gap_n   = '0;
                        end else begin
                            dwell_n = dwell_cnt + 1'b1;
                        end
                    end
                end
                GAP_TO_LVL: begin
                    if (gap_cnt == GAP_LAST) begin
                        state_n = SHOW_LVL;
                        gap_n   = '0;
                        dwell_n = '0;
                    end else begin
                        gap_n = gap_cnt + 1'b1;
                    end
                end
                SHOW_LVL: begin
                    if (force_level) begin
                        dwell_n = '0;
                    end else if (tick_en) begin
                        if (dwell_cnt == LVL_LAST) begin
                            state_n = GAP_TO_IRR;
                            dwell_n = '0;
                            gap_n   = '0;
                        end else begin
                            dwell_n = dwell_cnt + 1'b1;
                        end
                    end
                end
                GAP_TO_IRR: begin
                    if (gap_cnt == GAP_LAST) begin
                        state_n = force_level ? GAP_TO_LVL : SHOW_IRR;
                        gap_n   = '0;
                        dwell_n = '0;
                    end else begin
                        gap_n = gap_cnt + 1'b1;
                    end
                end
                ALARM: begin
                    state_n = GAP_TO_IRR;
                    dwell_n = '0;
                    gap_n   = '0;
                end
                default: begin
                    state_n = SHOW_IRR;
                    dwell_n = '0;
                    gap_n   = '0;
                end
            endcase
        end
    end

    always_comb begin
        sel_n   = 1'b1;
        blank_n = 1'b1;
        unique case (state_n)
            SHOW_IRR:   begin sel_n = 1'b0; blank_n = 1'b0; end
            GAP_TO_LVL: begin sel_n = 1'b0; blank_n = 1'b1; end
            SHOW_LVL:   begin sel_n = 1'b1; blank_n = 1'b0; end
            GAP_TO_IRR: begin sel_n = 1'b1; blank_n = 1'b1; end
            ALARM: begin
                sel_n   = 1'b1;
                // Lit on entry, then blinks on each tick.
                blank_n = (state == ALARM) ? (blank ^ tick_en) : 1'b0;
            end
            default: begin sel_n = 1'b0; blank_n = 1'b1; end
        endcase
        // Code follows the next-state source so a new frame never shows the old one.
        code_n = sel_n ? water_tank_level : irrigation_status;
        fs_n   = !run
              || ((state_n != state)
                  && (state_n == SHOW_IRR || state_n == SHOW_LVL))
              || ((state_n == ALARM) && (state != ALARM)
                  && (state != SHOW_LVL));
    end

endmodule

// File: tb/tb_display_mux_scheduler.sv
// Testbench for display_mux_scheduler: directed phases plus random stimulus,
// every cycle compared against a countdown-based behavioural model.
module tb_display_mux_scheduler;

    localparam int DI = 3;
    localparam int DL = 2;
    localparam int BK = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_1hz = 1'b0;
    logic [1:0] irrigation_status = 2'b00;
    logic [1:0] water_tank_level = 2'b00;
    logic       force_level = 1'b0;
    logic       display_sel;
    logic [1:0] display_code;
    logic       blank;
    logic       frame_start;

    display_mux_scheduler #(
        .DWELL_IRR (DI),
        .DWELL_LVL (DL),
        .BLANK_CLKS(BK)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .tick_1hz         (tick_1hz),
        .irrigation_status(irrigation_status),
        .water_tank_level (water_tank_level),
        .force_level      (force_level),
        .display_sel      (display_sel),
        .display_code     (display_code),
        .blank            (blank),
        .frame_start      (frame_start)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: what is on display, how long the current gap/frame has left.
    bit         m_started;
    bit         m_alarm;
    int         m_gap_left;
    bit         m_dest;
    bit         m_src;
    int         m_ticks_left;
    bit         m_blank;
    bit         m_fs;
    logic [1:0] m_code;

    task automatic model_reset();
        m_started    = 0;
        m_alarm      = 0;
        m_gap_left   = 0;
        m_dest       = 0;
        m_src        = 0;
        m_ticks_left = DI;
        m_blank      = 1;
        m_fs         = 0;
        m_code       = 2'b00;
    endtask

    task automatic enter_gap(input bit dest);
        m_gap_left = BK;
        m_dest     = dest;
        m_blank    = 1;
    endtask

    task automatic model_step(input logic [1:0] st, input logic [1:0] lv,
                              input logic frc, input logic tk);
        bit t, al, was_lvl;
        t       = tk && m_started;
        al      = (lv == 2'b00) && (st != 2'b00);
        was_lvl = !m_alarm && (m_gap_left == 0) && m_src;
        m_fs    = !m_started;
        m_started = 1;
        if (al) begin
            if (!m_alarm) begin
                if (!was_lvl) m_fs = 1;
                m_blank = 0;
            end else if (t) begin
                m_blank = !m_blank;
            end
            m_alarm    = 1;
            m_src      = 1;
            m_gap_left = 0;
        end else if (m_alarm) begin
            m_alarm = 0;
            enter_gap(0);
        end else if (m_gap_left > 0) begin
            m_gap_left--;
            if (m_gap_left == 0) begin
                if (m_dest == 0 && frc) begin
                    enter_gap(1);
                    m_src = 0;
                end else begin
                    m_src        = m_dest;
                    m_ticks_left = m_dest ? DL : DI;
                    m_blank      = 0;
                    m_fs         = 1;
                end
            end
        end else begin
            m_blank = 0;
            if (frc && !m_src) begin
                enter_gap(1);
            end else if (frc && m_src) begin
                m_ticks_left = DL;
            end else if (t) begin
                m_ticks_left--;
                if (m_ticks_left == 0) enter_gap(!m_src);
            end
        end
        m_code = m_src ? lv : st;
    endtask

    function automatic logic [4:0] exp_out();
        return {m_src, m_code, m_blank, m_fs};
    endfunction

    function automatic logic [4:0] dut_out();
        return {display_sel, display_code, blank, frame_start};
    endfunction

    task automatic cyc(input logic [1:0] st, input logic [1:0] lv,
                       input logic frc, input logic tk);
        @(negedge clk);
        check("out", 32'(dut_out()), 32'(exp_out()));
        irrigation_status = st;
        water_tank_level  = lv;
        force_level       = frc;
        tick_1hz          = tk;
        model_step(st, lv, frc, tk);
    endtask

    // Assert rst between edges; outputs must drop to reset values at once.
    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        tick_1hz = 1'b0;
        #1 check("async_rst", 32'(dut_out()), 32'(5'b0_00_1_0));
        model_reset();
        repeat (2) begin
            @(negedge clk);
            check("in_rst", 32'(dut_out()), 32'(exp_out()));
        end
        rst = 1'b0;
        model_step(irrigation_status, water_tank_level, force_level, 1'b0);
    endtask

    task automatic run_periodic(input int n, input int per,
                                input logic [1:0] st, input logic [1:0] lv,
                                input logic frc);
        for (int i = 0; i < n; i++)
            cyc(st, lv, frc, (i % per) == per - 1);
    endtask

    int seen_fs;
    int waited;

    initial begin
        model_reset();
        do_reset();

        // Normal rotation, ticks every 100 clks.
        run_periodic(1200, 100, 2'b10, 2'b11, 1'b0);

        // Status change while the irrigation frame is up.
        run_periodic(150, 100, 2'b01, 2'b11, 1'b0);
        run_periodic(150, 100, 2'b11, 2'b11, 1'b0);

        // Alarm mid-frame, blink, then recovery.
        run_periodic(50, 100, 2'b01, 2'b00, 1'b0);
        run_periodic(400, 100, 2'b01, 2'b00, 1'b0);
        run_periodic(400, 100, 2'b01, 2'b10, 1'b0);

        // Forced level frame for ~10 ticks, then release.
        run_periodic(1000, 100, 2'b10, 2'b01, 1'b1);
        run_periodic(400, 100, 2'b10, 2'b01, 1'b0);

        // Dense ticks: many land in gaps and on frame transitions.
        for (int i = 0; i < 800; i++)
            cyc(2'b11, 2'b10, 1'b0, ($urandom % 3) == 0);

        // Random traffic.
        begin
            logic [1:0] st, lv;
            logic frc;
            st  = 2'b01;
            lv  = 2'b10;
            frc = 1'b0;
            seen_fs = 0;
            for (int i = 0; i < 6000; i++) begin
                if ($urandom % 150 == 0) st = 2'($urandom);
                if ($urandom % 250 == 0) lv = 2'($urandom);
                if ($urandom % 400 == 0) frc = !frc;
                cyc(st, lv, frc, ($urandom % 25) == 0);
                if (frame_start) seen_fs++;
            end
            check("fs_seen", 32'(seen_fs > 10), 32'd1);
        end

        // Reset asserted in the middle of a gap toward the level frame.
        waited = 0;
        while (!(m_gap_left > 4 && m_gap_left < BK && m_dest && !m_alarm)
               && waited < 3000) begin
            cyc(2'b10, 2'b01, 1'b0, (waited % 40) == 39);
            waited++;
        end
        check("gap_reached", 32'(waited < 3000), 32'd1);
        do_reset();
        run_periodic(700, 100, 2'b10, 2'b01, 1'b0);

        @(negedge clk);
        check("final", 32'(dut_out()), 32'(exp_out()));
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
